// File: rtl/gen_free_list_if.sv
// gen_free_list_if: rename-side bundle for the physical-register
// free list (allocate, release, commit and recovery signals).
interface gen_free_list_if #(
    parameter int VIRT_ADDR_WIDTH = 8,
    parameter int ALLOC_PORTS     = 4,
    parameter int FREE_PORTS      = 4,
    parameter int CNT_WIDTH       = 9,
    parameter int COMMIT_WIDTH    = $clog2(ALLOC_PORTS + 1)
);
    logic [ALLOC_PORTS-1:0]                      alloc_req;
    logic                                        alloc_grant;
    logic [ALLOC_PORTS-1:0][VIRT_ADDR_WIDTH-1:0] alloc_tag;
    logic [FREE_PORTS-1:0]                       free_valid;
    logic [FREE_PORTS-1:0][VIRT_ADDR_WIDTH-1:0]  free_tag;
    logic [COMMIT_WIDTH-1:0]                     commit_count;
    logic                                        recover;
    logic [CNT_WIDTH-1:0]                        free_count;
    logic                                        low_water;

    modport master (
        output alloc_req, free_valid, free_tag, commit_count, recover,
        input  alloc_grant, alloc_tag, free_count, low_water
    );

    modport slave (
        input  alloc_req, free_valid, free_tag, commit_count, recover,
        output alloc_grant, alloc_tag, free_count, low_water
    );
endinterface

// File: rtl/gen_free_list.sv
// gen_free_list: circular free list of physical tags with a speculative
// head, a committed head for recovery, and a tail for released tags.
module gen_free_list #(
    parameter int ARCH_COUNT      = 32,
    parameter int VIRT_COUNT      = 256,
    parameter int VIRT_ADDR_WIDTH = $clog2(VIRT_COUNT),
    parameter int ALLOC_PORTS     = 4,
    parameter int FREE_PORTS      = 4,
    parameter int FREE_SLOTS      = VIRT_COUNT - ARCH_COUNT,
    parameter int CNT_WIDTH       = $clog2(VIRT_COUNT + 1)
) (
    input  logic           clk,
    input  logic           async_rst_n,
    input  logic           clk_en,
    gen_free_list_if.slave bus
);
    typedef logic [VIRT_ADDR_WIDTH-1:0] ptr_t;

    ptr_t mem [VIRT_COUNT];
    ptr_t head;
    ptr_t commit_head;
    ptr_t tail;
    ptr_t n_req;
    ptr_t n_free;
    ptr_t occ;
    ptr_t spec_cnt;
    ptr_t commit_inc;
    ptr_t alloc_ofs [ALLOC_PORTS];
    ptr_t free_ofs [FREE_PORTS];
    logic grant;

    assign commit_inc = ptr_t'(bus.commit_count);
    assign occ        = tail - head;
    assign spec_cnt   = head - commit_head;

    assign bus.free_count  = CNT_WIDTH'(occ);
    assign bus.low_water   = bus.free_count < CNT_WIDTH'(ALLOC_PORTS);
    assign grant           = async_rst_n & clk_en & ~bus.recover
                           & (bus.free_count >= CNT_WIDTH'(n_req));
    assign bus.alloc_grant = grant;

    // Requesting lanes take consecutive slots in lane order.
    always_comb begin
        n_req = '0;
        for (int k = 0; k < ALLOC_PORTS; k++) begin
            alloc_ofs[k] = n_req;
            n_req        = n_req + ptr_t'(bus.alloc_req[k]);
        end
    end

    // Releasing lanes append at the tail in lane order.
    always_comb begin
        n_free = '0;
        for (int k = 0; k < FREE_PORTS; k++) begin
            free_ofs[k] = n_free;
            n_free      = n_free + ptr_t'(bus.free_valid[k]);
        end
    end

    // Tag read-out straight from the speculative head.
    always_comb begin
        for (int k = 0; k < ALLOC_PORTS; k++) begin
            bus.alloc_tag[k] = mem[head + alloc_ofs[k]];
        end
    end

    // Pointer update; recover rewinds to the post-commit head.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            head        <= '0;
            commit_head <= '0;
            tail        <= ptr_t'(FREE_SLOTS);
        end else if (clk_en) begin
            commit_head <= commit_head + commit_inc;
            tail        <= tail + n_free;
            if (bus.recover) begin
                head <= commit_head + commit_inc;
            end else if (grant) begin
                head <= head + n_req;
            end
        end
    end

    // Tag storage: preloaded with the unmapped tags, refilled by release.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            for (int i = 0; i < VIRT_COUNT; i++) begin
                mem[i] <= (i < FREE_SLOTS) ? ptr_t'(ARCH_COUNT + i) : '0;
            end
        end else if (clk_en) begin
            for (int k = 0; k < FREE_PORTS; k++) begin
                if (bus.free_valid[k]) begin
                    mem[tail + free_ofs[k]] <= bus.free_tag[k];
                end
            end
        end
    end

    a_commit_past_head: assert property (
        @(posedge clk) disable iff (!async_rst_n)
        clk_en |-> (commit_inc <= spec_cnt));

    a_overfill: assert property (
        @(posedge clk) disable iff (!async_rst_n)
        clk_en |-> (int'(bus.free_count) + int'(n_free) <= FREE_SLOTS));

    a_known_ctrl: assert property (
        @(posedge clk) disable iff (!async_rst_n)
        !$isunknown({clk_en, bus.alloc_req, bus.free_valid,
                     bus.commit_count, bus.recover}));
endmodule

// File: tb/tb_gen_free_list.sv
// tb_gen_free_list: queue-based reference model of the free list with a
// scoreboard monitor comparing grant, tags, count and low-water flag.
module tb_gen_free_list;
    localparam int AW    = 8;
    localparam int NA    = 4;
    localparam int NF    = 4;
    localparam int CW    = 9;
    localparam int SLOTS = 224;

    typedef struct packed {
        logic               grant;
        logic [NA-1:0]      req;
        logic [NA-1:0][7:0] tags;
        logic [CW-1:0]      fcnt;
        logic               lw;
    } exp_t;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic clk_en = 1'b0;

    int tests = 0;
    int fails = 0;

    int free_q[$];
    int spec_q[$];
    int owned_q[$];
    exp_t exp_q[$];

    always #5 clk = ~clk;

    gen_free_list_if #(
        .VIRT_ADDR_WIDTH(AW), .ALLOC_PORTS(NA),
        .FREE_PORTS(NF), .CNT_WIDTH(CW)
    ) bus ();

    gen_free_list dut (
        .clk(clk),
        .async_rst_n(rst_n),
        .clk_en(clk_en),
        .bus(bus)
    );

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        free_q.delete();
        spec_q.delete();
        owned_q.delete();
        for (int i = 0; i < SLOTS; i++) free_q.push_back(32 + i);
        for (int i = 0; i < 32; i++) owned_q.push_back(i);
    endtask

    task automatic drop_owned(int t);
        int idx[$];
        idx = owned_q.find_first_index(x) with (x == t);
        if (idx.size() > 0) owned_q.delete(idx[0]);
    endtask

    // One cycle of stimulus; the expected outputs go to the scoreboard.
    task automatic drive(logic [NA-1:0] req, logic [NF-1:0] fv,
                         logic [NF-1:0][7:0] ft, int cc,
                         logic rec, logic en);
        exp_t e;
        int n;
        int k;
        @(negedge clk);
        bus.alloc_req    = req;
        bus.free_valid   = fv;
        bus.free_tag     = ft;
        bus.commit_count = 3'(cc);
        bus.recover      = rec;
        clk_en           = en;
        n      = $countones(req);
        e.req  = req;
        e.fcnt = CW'(free_q.size());
        e.lw   = free_q.size() < NA;
        e.grant = en && !rec && (free_q.size() >= n);
        e.tags = '0;
        k = 0;
        for (int l = 0; l < NA; l++) begin
            if (req[l]) begin
                if (k < free_q.size()) e.tags[l] = 8'(free_q[k]);
                k++;
            end
        end
        exp_q.push_back(e);
        if (en) begin
            if (e.grant) repeat (n) spec_q.push_back(free_q.pop_front());
            repeat (cc) owned_q.push_back(spec_q.pop_front());
            if (rec) begin
                while (spec_q.size() > 0) free_q.push_front(spec_q.pop_back());
            end
            for (int l = 0; l < NF; l++) begin
                if (fv[l]) begin
                    free_q.push_back(int'(ft[l]));
                    drop_owned(int'(ft[l]));
                end
            end
        end
    endtask

    // Reset asserted mid-cycle with a full request pending.
    task automatic do_reset();
        @(negedge clk);
        #3;
        bus.alloc_req    = 4'hF;
        bus.free_valid   = '0;
        bus.recover      = 1'b0;
        bus.commit_count = '0;
        clk_en           = 1'b1;
        rst_n            = 1'b0;
        #1;
        chk("rst_free_count", 32'(bus.free_count), 224);
        chk("rst_low_water", 32'(bus.low_water), 0);
        chk("rst_grant", 32'(bus.alloc_grant), 0);
        for (int l = 0; l < NA; l++) begin
            chk($sformatf("rst_tag%0d", l), 32'(bus.alloc_tag[l]), 32 + l);
        end
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Scoreboard monitor: one expected record per driven cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("grant", 32'(bus.alloc_grant), 32'(e.grant));
                chk("free_count", 32'(bus.free_count), 32'(e.fcnt));
                chk("low_water", 32'(bus.low_water), 32'(e.lw));
                if (e.grant) begin
                    for (int l = 0; l < NA; l++) begin
                        if (e.req[l]) begin
                            chk($sformatf("alloc_tag%0d", l),
                                32'(bus.alloc_tag[l]), 32'(e.tags[l]));
                        end
                    end
                end
            end
        end
    end

    initial begin
        logic [NF-1:0][7:0] ft;
        logic [NF-1:0]      fv;
        int cc;
        int lim;
        int base;
        int m;

        bus.alloc_req    = '0;
        bus.free_valid   = '0;
        bus.free_tag     = '0;
        bus.commit_count = '0;
        bus.recover      = 1'b0;
        model_reset();

        do_reset();
        drive(4'hF, '0, '0, 0, 1'b0, 1'b1);
        drive(4'hF, '0, '0, 0, 1'b0, 1'b1);
        drive(4'h0, '0, '0, 0, 1'b0, 1'b1);

        do_reset();
        drive(4'b1010, '0, '0, 0, 1'b0, 1'b1);
        drive(4'h0, '0, '0, 0, 1'b0, 1'b1);

        do_reset();
        repeat (56) drive(4'hF, '0, '0, 0, 1'b0, 1'b1);
        ft = '0;
        ft[0] = 8'd7;
        drive(4'b0001, 4'b0001, ft, 0, 1'b0, 1'b1);
        drive(4'b0001, '0, '0, 0, 1'b0, 1'b1);

        do_reset();
        drive(4'hF, '0, '0, 0, 1'b0, 1'b1);
        drive(4'hF, '0, '0, 0, 1'b0, 1'b1);
        drive(4'h0, '0, '0, 3, 1'b0, 1'b1);
        drive(4'h0, '0, '0, 0, 1'b1, 1'b1);
        drive(4'b0001, '0, '0, 0, 1'b0, 1'b1);
        drive(4'hF, '0, '0, 0, 1'b0, 1'b1);
        drive(4'h0, '0, '0, 2, 1'b1, 1'b1);
        drive(4'b0001, '0, '0, 0, 1'b0, 1'b1);

        do_reset();
        drive(4'hF, '0, '0, 0, 1'b0, 1'b1);
        for (int c = 0; c < 100; c++) begin
            for (int l = 0; l < NF; l++) ft[l] = 8'(owned_q[l]);
            drive(4'hF, 4'hF, ft, spec_q.size(), 1'b0, 1'b1);
        end

        for (int l = 0; l < NF; l++) ft[l] = 8'(owned_q[l]);
        drive(4'hF, 4'hF, ft, 2, 1'b1, 1'b0);
        drive(4'h0, '0, '0, 0, 1'b0, 1'b1);

        for (int c = 0; c < 400; c++) begin
            if (c == 200) do_reset();
            cc  = $urandom_range(0, spec_q.size() < 4 ? spec_q.size() : 4);
            fv  = 4'($urandom);
            ft  = '0;
            lim = owned_q.size() - 32;
            base = $urandom_range(0, owned_q.size() - 1);
            m = 0;
            for (int l = 0; l < NF; l++) begin
                if (fv[l]) begin
                    if (m < lim) begin
                        ft[l] = 8'(owned_q[(base + m) % owned_q.size()]);
                        m++;
                    end else begin
                        fv[l] = 1'b0;
                    end
                end
            end
            drive(4'($urandom), fv, ft, cc,
                  $urandom_range(0, 19) == 0,
                  $urandom_range(0, 9) != 0);
        end

        drive(4'h0, '0, '0, 0, 1'b0, 1'b1);
        @(negedge clk);
        #4;
        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/gen_free_list.md
Name: gen_free_list

Overview:
- Physical-register free list for the rename stage. It is the allocate/reclaim counterpart of the architectural-to-physical map table.
- Hands out up to ALLOC_PORTS free physical tags per cycle to rename.
- Accepts tags released at commit.
- Restores speculatively allocated tags on pipeline recovery, using a committed head pointer.

Parameters:
- ARCH_COUNT, 32, architectural registers; tags 0..ARCH_COUNT-1 are mapped at reset and never start free.
- VIRT_COUNT, 256, physical registers. Must be a power of 2 and greater than ARCH_COUNT.
- VIRT_ADDR_WIDTH, $clog2(VIRT_COUNT), physical tag width.
- ALLOC_PORTS, 4, allocation lanes per cycle.
- FREE_PORTS, 4, release lanes per cycle.
- FREE_SLOTS, VIRT_COUNT-ARCH_COUNT, maximum tags held in the list (224).
- CNT_WIDTH, $clog2(VIRT_COUNT+1), width of the free count.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- async_rst_n  in  1  asynchronous active-low reset.
- clk_en  in  1  when low: no state update, alloc_grant forced to 0.
- alloc_req  in  [ALLOC_PORTS]  per-lane request for one tag.
- alloc_grant  out  1  all requested lanes are served this cycle (all-or-nothing).
- alloc_tag  out  [VIRT_ADDR_WIDTH] x [ALLOC_PORTS]  tag for each requesting lane.
- free_valid  in  [FREE_PORTS]  per-lane tag release (old mapping retired at commit).
- free_tag  in  [VIRT_ADDR_WIDTH] x [FREE_PORTS]  tag being released.
- commit_count  in  $clog2(ALLOC_PORTS+1)  number of earlier allocations committed this cycle.
- recover  in  1  discard all uncommitted allocations.
- free_count  out  CNT_WIDTH  tags currently available (tail minus head).
- low_water  out  1  free_count < ALLOC_PORTS.

Behaviour:
- Storage:
  - Circular buffer mem[VIRT_COUNT] of tags.
  - Pointers head (speculative read), commit_head (committed read) and tail (write), each VIRT_ADDR_WIDTH bits, wrapping modulo VIRT_COUNT.
  - Occupancy never exceeds FREE_SLOTS < VIRT_COUNT, so the pointers need no extra wrap bit.
- Reset (asynchronous, any time, including mid-operation):
  - mem[i] = ARCH_COUNT+i for i < FREE_SLOTS; remaining entries are don't-care.
  - head = commit_head = 0; tail = FREE_SLOTS.
  - free_count = 224, low_water = 0, alloc_grant = 0.
  - alloc_tag[k] = 32+k once all alloc_req bits are set.
- Allocation (combinational, same cycle):
  - n_req = popcount(alloc_req).
  - Lane k's tag = mem[head + popcount(alloc_req[k-1:0])], so requesting lanes receive consecutive tags in lane order.
  - alloc_tag for non-requesting lanes is don't-care.
  - alloc_grant = clk_en & !recover & (free_count >= n_req). alloc_grant is 1 when n_req = 0.
  - On the clock edge with alloc_grant=1: head += n_req.
  - On the clock edge with alloc_grant=0: head is unchanged and no lane is served.
- Release:
  - With clk_en=1, valid lanes write mem[tail + popcount(free_valid[k-1:0])] = free_tag[k].
  - tail += popcount(free_valid).
  - Released tags become allocatable the next cycle, never in the same cycle.
  - Release is not blocked by recover.
- Commit: with clk_en=1, commit_head += commit_count.
- Recover:
  - With clk_en=1, head <= commit_head + commit_count, so commit applies before recover in the same cycle.
  - No allocation occurs that cycle.
  - free_count the following cycle = tail_next - head_next.
- Simultaneous events: alloc, free and commit may all occur in one cycle. Each pointer update is independent. free_count next = current - granted n_req + popcount(free_valid).
- Illegal conditions (simulation assertions; RTL behaviour undefined):
  - commit would move commit_head past head.
  - free_count + popcount(free_valid) > FREE_SLOTS.
  - Any X on control inputs while out of reset.
- low_water and free_count are combinational from the registered pointers.

Test Plan:
- Reset, then alloc_req=4'b1111 for one cycle -> alloc_grant=1, alloc_tag=32,33,34,35; next cycle free_count=220, alloc_tag shows 36..39.
- alloc_req=4'b1010 -> lane1 gets 32, lane3 gets 33; head advances by 2; free_count=222.
- Allocate 56 cycles x 4 (free_count=0, low_water=1), then request 1 -> alloc_grant=0. Same cycle free_valid=1, free_tag=7 -> next cycle alloc_req=0001 grants tag 7.
- Allocate 8 tags, commit_count=3, then recover -> free_count returns to 224-3=221 and next alloc_tag[0]=35. Recover asserted with commit_count=2 in the same cycle -> head = old commit_head+2.
- Run pointers past index 255 with a steady 4-alloc/4-free loop for 100 cycles -> tags wrap correctly, free_count is constant, and each freed tag is issued again exactly once in FIFO order.
- clk_en=0 with requests, frees and recover asserted -> no pointer change and alloc_grant=0. Assert async_rst_n low mid-burst -> all state returns to reset values immediately.
